mem_responder: RTL

// - Memory-side responder for the datapath's MAR/MDR memory interface: services Read/Write requests
//   and returns read data on Mdatain, which the MDR captures.
// - Sits between the MAR/MDR pair and a synchronous single-port word RAM.
// - Inserts a programmable number of wait states.
// - Completes each transfer with a 4-phase request/done handshake.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ram_sp_sync.sv | 25 ++
 rtl/mem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
// FSM state encoding, operation type, wait-counter width and default bus widths.
package cpu_pkg;

  localparam int unsigned WAIT_CW    = 4;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/ram_sp_sync.sv
// Synchronous single-port word RAM with registered read data.
// Contents are not reset; a read during a write returns the old word.
module ram_sp_sync #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: services Read/Write requests against a
// synchronous RAM with programmable wait states and a 4-phase request/done handshake.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_CW-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;

  logic              req_any;
  logic              req_bad;
  logic              accept;
  logic              commit;

  logic              done_d;
  logic              busy_d;
  logic              err_d;
  logic              load_rd;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign req_any = Read | Write;
  assign req_bad = Read & Write;
  assign accept  = (state_q == ST_IDLE) && (Read ^ Write);
  // WAIT lasts WAIT_CYCLES+1 cycles, so done follows the accept edge by 1+WAIT_CYCLES edges
  assign commit  = (state_q == ST_WAIT) && (cnt_q == '0);

  // The RAM is pre-addressed from MAR while idle so its registered read is ready by commit
  assign ram_addr = (state_q == ST_IDLE) ? MAR_addr : addr_q;

  ram_sp_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_bad) begin
          state_d = ST_DRAIN;
        end else if (req_any) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (commit) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!req_any) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and RAM-control decode
  always_comb begin
    done_d  = mem_done;
    busy_d  = mem_busy;
    err_d   = 1'b0;
    load_rd = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_bad) begin
          err_d = 1'b1;
        end else if (req_any) begin
          busy_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (commit) begin
          done_d  = 1'b1;
          ram_we  = (op_q == OP_WRITE);
          load_rd = (op_q == OP_READ);
        end
      end
      ST_ACK: begin
        if (!req_any) begin
          done_d = 1'b0;
          busy_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!req_any) begin
          busy_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Request latch, wait counter and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= OP_READ;
      Mdatain  <= '0;
      mem_done <= 1'b0;
      mem_busy <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= MAR_addr;
        wdata_q <= MDR_wdata;
        op_q    <= Write ? OP_WRITE : OP_READ;
        cnt_q   <= WAIT_CW'(WAIT_CYCLES);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - WAIT_CW'(1);
      end
      if (load_rd) begin
        Mdatain <= ram_rdata;
      end
      mem_done <= done_d;
      mem_busy <= busy_d;
      mem_err  <= err_d;
    end
  end

endmodule
